vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//   Pixel-coordinate source for the display path: generates 640x480@60 VGA timing from the 100 MHz clk.
//   Drives x_crd/y_crd to the game renderer, takes its 1-bit red/green/blue back, and drives the monitor.
//   The monitor outputs are hsync, vsync and colour gated by video_on, all aligned to the same clk.
//   Also emits pix_tick and a once-per-frame frame_start strobe for game-state update logic.
// PARAMETERS
//   CLK_DIV    4    clk cycles per pixel (100 MHz -> 25 MHz pixel rate); must be >= 2
//   H_VISIBLE  640  visible pixels per line
//   H_FRONT    16   horizontal front porch, pixels
//   H_SYNC     96   horizontal sync width, pixels
//   H_BACK     48   horizontal back porch, pixels
//   V_VISIBLE  480  visible lines per frame
//   V_FRONT    10   vertical front porch, lines
//   V_SYNC     2    vertical sync width, lines
//   V_BACK     33   vertical back porch, lines
//   SYNC_POL   0    active level of hsync/vsync (0 = active-low)
// PORTS
//   clk          in   1   system clock, 100 MHz
//   rst_n        in   1   asynchronous active-low reset
//   red_in       in   1   renderer red for current x_crd/y_crd (combinational in renderer)
//   green_in     in   1   renderer green
//   blue_in      in   1   renderer blue
//   x_crd        out  10  horizontal pixel counter, 0..H_TOTAL-1
//   y_crd        out  10  vertical line counter, 0..V_TOTAL-1
//   pix_tick     out  1   one-clk strobe, one per pixel period
//   frame_start  out  1   one-clk strobe on the last pixel of each frame
//   video_on     out  1   registered; high while displayed pixel is visible
//   hsync        out  1   registered horizontal sync
//   vsync        out  1   registered vertical sync
//   red_out      out  1   red_in & visible, registered
//   green_out    out  1   green_in & visible, registered
//   blue_out     out  1   blue_in & visible, registered
// BEHAVIOUR
//   - H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525). Elaboration error if either > 1024.
//   - Reset (async, immediate, also mid-frame):
//     - div, x_crd, y_crd, pix_tick, frame_start, video_on and RGB outputs go to 0.
//     - hsync and vsync go to ~SYNC_POL.
//   - Divider: div counts 0..CLK_DIV-1 and wraps. pix_tick is high in the clk when div == CLK_DIV-1.
//   - Counters advance only on the clk edge where pix_tick == 1:
//     - x_crd wraps H_TOTAL-1 -> 0.
//     - y_crd increments on the x wrap only; it wraps V_TOTAL-1 -> 0 on the same edge.
//   - frame_start = pix_tick & (x_crd == H_TOTAL-1) & (y_crd == V_TOTAL-1).
//   - Output stage: every clk edge registers from the current x_crd/y_crd and RGB inputs. Latency is exactly 1 clk:
//     - visible = (x_crd < H_VISIBLE) & (y_crd < V_VISIBLE).
//     - video_on <= visible; colour_out <= colour_in & visible.
//     - hsync <= SYNC_POL when x_crd in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751], else ~SYNC_POL.
//     - vsync <= SYNC_POL when y_crd in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] = [490,491], else ~SYNC_POL.
//   - Off-screen colour: renderer input is don't-care outside the visible area. Output is forced 0 there, which covers pipes with x > 639.
//   - Counter compares are 10-bit unsigned. No other state: no FSM beyond the three counters.
// STRUCTURE
//   - Shared include vga_params.vh: 640x480@60 timing constants and derived H_TOTAL/V_TOTAL, sync start/end.
//   - Sub-module pixel_tick_gen (param CLK_DIV; ports clk, rst_n, tick) implements the divider.
//   - Counters and the output register stage stay in vga_timing_gen.
// TESTING
//   1. Assert rst_n=0 mid-line at x=300,y=100. All outputs must take their reset values without a clk edge. Release: first pix_tick 4 clks later, x_crd=1.
//   2. Free-run one line. x_crd returns to 0 every 3200 clks. hsync is low for exactly 384 consecutive clks, starting 1 clk after x_crd becomes 656.
//   3. Free-run two frames. frame_start pulses are 1,680,000 clks apart, each 1 clk wide. vsync is low for 2 lines (6400 clks) starting 1 clk after y_crd becomes 490.
//   4. Tie red_in=green_in=blue_in=1. The RGB outputs must be high only while video_on: x 0..639 and y 0..479, delayed 1 clk. They must be 0 at x=700 and at y=500.
//   5. Drive green_in = (x_crd == 100). green_out must be high for exactly 4 clks per visible line, starting 1 clk after x_crd becomes 100.
//   6. Count video_on clks over one frame: must equal 640*480*4 = 1,228,800.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants for the 640x480@60 VGA path, plus a small range helper.
package vga_timing_gen_pkg;

    // Width of the x/y pixel counters and the largest total they can hold
    localparam int CRD_W     = 10;
    localparam int CRD_LIMIT = 1 << CRD_W;

    // Default 640x480@60 timing from a 100 MHz system clock
    localparam int   DEF_CLK_DIV   = 4;
    localparam int   DEF_H_VISIBLE = 640;
    localparam int   DEF_H_FRONT   = 16;
    localparam int   DEF_H_SYNC    = 96;
    localparam int   DEF_H_BACK    = 48;
    localparam int   DEF_V_VISIBLE = 480;
    localparam int   DEF_V_FRONT   = 10;
    localparam int   DEF_V_SYNC    = 2;
    localparam int   DEF_V_BACK    = 33;
    localparam logic DEF_SYNC_POL  = 1'b0;

    // Inclusive unsigned range test on a counter value
    function automatic logic in_span(input logic [CRD_W-1:0] v,
                                     input logic [CRD_W-1:0] lo,
                                     input logic [CRD_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick_gen.sv
// Clock divider: emits a one-clk tick every CLK_DIV system clocks.
module pixel_tick_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("pixel_tick_gen: CLK_DIV must be at least 2");
    end

    localparam int            DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    // Free-running modulo-CLK_DIV counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + DW'(1);
        end
    end

    // Tick is decoded from the count so it is low whenever div is held at 0
    assign tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel/line counters, frame strobe and a registered
// monitor-side stage (syncs, video_on and gated colour, 1 clk after x/y).
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   CLK_DIV   = DEF_CLK_DIV,
    parameter int   H_VISIBLE = DEF_H_VISIBLE,
    parameter int   H_FRONT   = DEF_H_FRONT,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BACK    = DEF_H_BACK,
    parameter int   V_VISIBLE = DEF_V_VISIBLE,
    parameter int   V_FRONT   = DEF_V_FRONT,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BACK    = DEF_V_BACK,
    parameter logic SYNC_POL  = DEF_SYNC_POL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             red_in,
    input  logic             green_in,
    input  logic             blue_in,
    output logic [CRD_W-1:0] x_crd,
    output logic [CRD_W-1:0] y_crd,
    output logic             pix_tick,
    output logic             frame_start,
    output logic             video_on,
    output logic             hsync,
    output logic             vsync,
    output logic             red_out,
    output logic             green_out,
    output logic             blue_out
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > CRD_LIMIT) begin : g_bad_h
        $error("vga_timing_gen: H_TOTAL does not fit the x counter");
    end
    if (V_TOTAL > CRD_LIMIT) begin : g_bad_v
        $error("vga_timing_gen: V_TOTAL does not fit the y counter");
    end

    localparam logic [CRD_W-1:0] X_LAST   = CRD_W'(H_TOTAL - 1);
    localparam logic [CRD_W-1:0] Y_LAST   = CRD_W'(V_TOTAL - 1);
    localparam logic [CRD_W-1:0] X_VIS    = CRD_W'(H_VISIBLE);
    localparam logic [CRD_W-1:0] Y_VIS    = CRD_W'(V_VISIBLE);
    localparam logic [CRD_W-1:0] HS_FIRST = CRD_W'(H_VISIBLE + H_FRONT);
    localparam logic [CRD_W-1:0] HS_LAST  = CRD_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CRD_W-1:0] VS_FIRST = CRD_W'(V_VISIBLE + V_FRONT);
    localparam logic [CRD_W-1:0] VS_LAST  = CRD_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic visible;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (pix_tick)
    );

    // Pixel and line counters, stepped once per pixel period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_crd <= '0;
            y_crd <= '0;
        end else if (pix_tick) begin
            if (x_crd == X_LAST) begin
                x_crd <= '0;
                if (y_crd == Y_LAST) begin
                    y_crd <= '0;
                end else begin
                    y_crd <= y_crd + CRD_W'(1);
                end
            end else begin
                x_crd <= x_crd + CRD_W'(1);
            end
        end
    end

    assign frame_start = pix_tick & (x_crd == X_LAST) & (y_crd == Y_LAST);
    assign visible     = (x_crd < X_VIS) & (y_crd < Y_VIS);

    // Monitor-side register stage; colour is blanked outside the visible area
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            video_on  <= 1'b0;
            hsync     <= ~SYNC_POL;
            vsync     <= ~SYNC_POL;
            red_out   <= 1'b0;
            green_out <= 1'b0;
            blue_out  <= 1'b0;
        end else begin
            video_on  <= visible;
            hsync     <= in_span(x_crd, HS_FIRST, HS_LAST) ? SYNC_POL : ~SYNC_POL;
            vsync     <= in_span(y_crd, VS_FIRST, VS_LAST) ? SYNC_POL : ~SYNC_POL;
            red_out   <= red_in & visible;
            green_out <= green_in & visible;
            blue_out  <= blue_in & visible;
        end
    end

endmodule
